// File: rtl/uart_echo_fifo_if.sv
// Handshake bundle between the echo FIFO, the UART rx/tx pair and the board displays.
interface uart_echo_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  logic                    rx_ready;
  logic [DATA_WIDTH-1:0]   rx_data;
  logic                    tx_busy;
  logic                    clear_overflow;
  logic                    tx_write;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic [DATA_WIDTH-1:0]   last_data;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;

  modport slave (
    input  rx_ready, rx_data, tx_busy, clear_overflow,
    output tx_write, tx_data, last_data, level, overflow
  );

  modport master (
    output rx_ready, rx_data, tx_busy, clear_overflow,
    input  tx_write, tx_data, last_data, level, overflow
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// Buffered UART loopback: received words are queued and drained to the transmitter by a small FSM.
// Optional feature: define UART_ECHO_CRLF_EN to append an LF after every accepted CR.
module uart_echo_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  uart_echo_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [LW-1:0]         level_reg;
  logic                  overflow_reg;
  logic [DATA_WIDTH-1:0] last_data_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;
  logic                  tx_write_reg;
  logic [1:0]            state_reg;
  logic [TW-1:0]         timer_reg;

  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  room;
  logic                  drop;
  logic [DATA_WIDTH-1:0] push_data;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a word then.
  assign pop  = (state_reg == ST_IDLE) && (level_reg != '0) && !bus.tx_busy;
  assign room = (level_reg < LW'(DEPTH)) || pop;
  assign push = push_req && room;

`ifdef UART_ECHO_CRLF_EN
  logic lf_pending_reg;
  logic lf_pending_next;

  // The pending LF owns the write port; a colliding rx word is lost.
  assign push_req        = lf_pending_reg || bus.rx_ready;
  assign push_data       = lf_pending_reg ? DATA_WIDTH'(8'h0A) : bus.rx_data;
  assign drop            = (push_req && !room) || (lf_pending_reg && bus.rx_ready);
  assign lf_pending_next = push && !lf_pending_reg && (push_data[7:0] == 8'h0D);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lf_pending_reg <= 1'b0;
    end else begin
      lf_pending_reg <= lf_pending_next;
    end
  end
`else
  assign push_req  = bus.rx_ready;
  assign push_data = bus.rx_data;
  assign drop      = push_req && !room;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      last_data_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        level_reg <= level_reg + 1'b1;
      end else if (pop && !push) begin
        level_reg <= level_reg - 1'b1;
      end
      // Drop beats clear when both land in the same cycle.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.clear_overflow) begin
        overflow_reg <= 1'b0;
      end
      if (bus.rx_ready) begin
        last_data_reg <= bus.rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      tx_write_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      tx_write_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            tx_data_reg  <= mem[rd_ptr_reg];
            tx_write_reg <= 1'b1;
            timer_reg    <= '0;
            state_reg    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          // timer_reg counts cycles since tx_write was presented.
          if (bus.tx_busy) begin
            state_reg <= ST_WAIT_DONE;
          end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_write  = tx_write_reg;
  assign bus.tx_data   = tx_data_reg;
  assign bus.last_data = last_data_reg;
  assign bus.level     = level_reg;
  assign bus.overflow  = overflow_reg;

endmodule
